nibble_serial_add_ctrl: RTL

//   Sequences one 4-bit ripple-carry adder slice over WIDTH-bit operands, one nibble per cycle, LSB first.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 13 +
 rtl/nibble_serial_add_ctrl_add_slice4.sv | 24 ++
 rtl/nibble_serial_add_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: state encodings and slice geometry.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W   = 4;
    localparam int CALC_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_add_slice4.sv
// Combinational 4-bit ripple-carry adder slice shared across all nibbles of an operation.
import nibble_serial_add_ctrl_pkg::*;

module add_slice4 (
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c_in,
    output logic [NIBBLE_W-1:0] sum,
    output logic                c_out
);

    logic carry;

    always_comb begin
        sum   = '0;
        carry = c_in;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial add controller: one 4-bit slice walks WIDTH-bit operands LSB nibble first.
// Optional subtract mode (op_sub port) is built when NSA_SUB_MODE_EN is defined.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start handshake, start_ready high
// ST_RUN  | one nibble per cycle through the slice, carry registered
// ST_DONE | result held on res_sum/res_c_out until the sink accepts
import nibble_serial_add_ctrl_pkg::*;

module nibble_serial_add_ctrl #(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             c_in,
`ifdef NSA_SUB_MODE_EN
    input  logic             op_sub,
`endif
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_c_out
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = $clog2(NIBBLES);

    state_t state;
    state_t state_nxt;
    logic   load;

    logic [CNT_W-1:0]          cnt;
    logic                      carry;
    logic [WIDTH-1:0]          a_sh;
    logic [WIDTH-1:0]          b_sh;
    // Only the upper nibbles need storing; the newest nibble comes straight from the slice.
    logic [WIDTH-NIBBLE_W-1:0] sum_sh;
    logic [WIDTH-1:0]          sum_nxt;

    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_c;
    logic                last_nibble;
    logic                init_carry;

`ifdef NSA_SUB_MODE_EN
    logic sub_q;
    assign slice_b    = sub_q ? ~b_sh[NIBBLE_W-1:0] : b_sh[NIBBLE_W-1:0];
    assign init_carry = op_sub ? 1'b1 : c_in;
`else
    assign slice_b    = b_sh[NIBBLE_W-1:0];
    assign init_carry = c_in;
`endif

    add_slice4 u_slice (
        .a     (a_sh[NIBBLE_W-1:0]),
        .b     (slice_b),
        .c_in  (carry),
        .sum   (slice_sum),
        .c_out (slice_c)
    );

    assign last_nibble = (cnt == CNT_W'(NIBBLES - 1));
    assign sum_nxt     = {slice_sum, sum_sh};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        busy        = 1'b0;
        res_valid   = 1'b0;
        load        = 1'b0;
        case (state)
            ST_IDLE: begin
                start_ready = 1'b1;
                if (start_valid) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_nibble) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            carry     <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            res_sum   <= '0;
            res_c_out <= 1'b0;
`ifdef NSA_SUB_MODE_EN
            sub_q     <= 1'b0;
`endif
        end else if (load) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= init_carry;
            cnt   <= '0;
`ifdef NSA_SUB_MODE_EN
            sub_q <= op_sub;
`endif
        end else if (state == ST_RUN) begin
            a_sh   <= a_sh >> NIBBLE_W;
            b_sh   <= b_sh >> NIBBLE_W;
            sum_sh <= sum_nxt[WIDTH-1:NIBBLE_W];
            carry  <= slice_c;
            cnt    <= cnt + CNT_W'(1);
            if (last_nibble) begin
                res_sum   <= sum_nxt;
                res_c_out <= slice_c;
            end
        end
    end

endmodule
